i2s_rx: RTL

//  Slave-mode I2S receiver for an external 2-channel ADC (PCM1808 class) or an S/PDIF-to-I2S bridge.
//  The external device drives BCK, LRCK and DIN. All three are oversampled in the clk domain.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_sync_edge.sv | 33 +++
 rtl/i2s_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the slave-mode I2S receiver.
// Optional status outputs are enabled by the I2S_RX_STATUS_EN macro in i2s_rx.
package i2s_pkg;

  localparam int   I2S_SAMPLE_W = 16;
  localparam int   I2S_CNT_W    = 6;
  localparam logic I2S_LEFT     = 1'b0;
  localparam logic I2S_RIGHT    = 1'b1;
  localparam int   BCK_TIMEOUT  = 256;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// 2-flop synchronizer for level inputs plus a 3-flop rise detector for the
// edge input; all sync outputs share the same delay so they stay aligned.
module i2s_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_edge,
  input  logic [W-1:0] i_async,
  output logic         o_rise,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [2:0]   r_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_e  <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_e  <= {r_e[1:0], i_edge};
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_e[1] & ~r_e[2];

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: oversamples BCK/LRCK/DIN and emits one L/R pair per frame.
// Define I2S_RX_STATUS_EN to add the o_err pulse and saturating o_err_count outputs.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int CNT_W    = I2S_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_i2s_bck,
  input  logic                i_i2s_lrck,
  input  logic                i_i2s_din,
  output logic [SAMPLE_W-1:0] o_left,
  output logic [SAMPLE_W-1:0] o_right,
  output logic                o_valid,
`ifdef I2S_RX_STATUS_EN
  output logic                o_err,
  output logic [7:0]          o_err_count,
`endif
  output logic                o_locked
);

  localparam logic [CNT_W-1:0] SW_C     = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       TMO_LOAD = 8'(BCK_TIMEOUT - 1);

  logic                w_bck_rise;
  logic [1:0]          w_sync;
  logic                w_lrck_s;
  logic                w_din_s;
  logic                w_slot_start;
  logic                w_timeout;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [SAMPLE_W-1:0] w_sh_shift;
  logic                w_short;
  logic [SAMPLE_W-1:0] w_word;
  state_t              w_state_nxt;
  logic                w_hold_en;
  logic                w_commit;

  state_t              r_state;
  logic                r_lrck_d;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_word_r;
  logic                r_commit;
  logic [7:0]          r_timer;

  i2s_sync_edge #(.W(2)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_edge  (i_i2s_bck),
    .i_async ({i_i2s_din, i_i2s_lrck}),
    .o_rise  (w_bck_rise),
    .o_sync  (w_sync)
  );

  assign w_lrck_s = w_sync[0];
  assign w_din_s  = w_sync[1];

  // The bit taken at a slot change is the LSB of the slot that is ending.
  assign w_slot_start = w_bck_rise && (w_lrck_s != r_lrck_d);
  assign w_cnt_inc    = (r_bitcnt == CNT_MAX) ? r_bitcnt : r_bitcnt + CNT_W'(1);
  assign w_sh_shift   = (r_bitcnt < SW_C) ? {r_shreg[SAMPLE_W-2:0], w_din_s} : r_shreg;
  assign w_short      = (w_cnt_inc < SW_C);
  assign w_word       = w_short ? (w_sh_shift << (SW_C - w_cnt_inc)) : w_sh_shift;
  assign w_timeout    = (r_timer == 8'd0) && !w_bck_rise;

  always_comb begin
    w_state_nxt = r_state;
    o_locked    = 1'b0;
    w_hold_en   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_slot_start && (r_lrck_d == I2S_RIGHT)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_locked = 1'b1;
        if (w_timeout) begin
          w_state_nxt = ST_ALIGN;
          o_locked    = 1'b0;
        end else if (w_slot_start) begin
          if (r_lrck_d == I2S_LEFT) w_hold_en = 1'b1;
          else                      w_commit  = 1'b1;
        end
      end
      default: w_state_nxt = ST_ALIGN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_ALIGN;
      r_lrck_d <= 1'b0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_hold_l <= '0;
      r_word_r <= '0;
      r_commit <= 1'b0;
      r_timer  <= '0;
      o_left   <= '0;
      o_right  <= '0;
      o_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bck_rise)           r_timer <= TMO_LOAD;
      else if (r_timer != 8'd0) r_timer <= r_timer - 8'd1;
      if (w_bck_rise) begin
        r_lrck_d <= w_lrck_s;
        if (w_slot_start) begin
          r_bitcnt <= '0;
          r_shreg  <= '0;
        end else begin
          r_bitcnt <= w_cnt_inc;
          r_shreg  <= w_sh_shift;
        end
      end
      if (w_hold_en) r_hold_l <= w_word;
      if (w_commit)  r_word_r <= w_word;
      r_commit <= w_commit;
      o_valid  <= r_commit;
      if (r_commit) begin
        o_left  <= r_hold_l;
        o_right <= r_word_r;
      end
    end
  end

`ifdef I2S_RX_STATUS_EN
  logic [CNT_W-1:0] r_len_l;
  logic             r_short_l;
  logic             r_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_l     <= '0;
      r_short_l   <= 1'b0;
      r_frame_err <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      if (w_hold_en) begin
        r_len_l   <= w_cnt_inc;
        r_short_l <= w_short;
      end
      if (w_commit) r_frame_err <= r_short_l | w_short | (r_len_l != w_cnt_inc);
      o_err <= r_commit & r_frame_err;
      if (r_commit && r_frame_err && (o_err_count != 8'hFF))
        o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule
